// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and defaults for the two-client memory arbiter.
// Supplies fallback values for MEM_ADDR_SIZE / MEM_BANDWIDTH when the
// surrounding build has not defined them.

`ifndef MEM_ADDR_SIZE
`define MEM_ADDR_SIZE 32
`endif
`ifndef MEM_BANDWIDTH
`define MEM_BANDWIDTH 8
`endif

package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_WAIT = 2'd1,
    WRITE     = 2'd2
  } arb_state_t;

  typedef enum logic {
    CLIENT_IC = 1'b0,
    CLIENT_DC = 1'b1
  } client_t;

  localparam int ARB_TIMEOUT_DEFAULT = 64;

  function automatic client_t other_client(input client_t c);
    return (c == CLIENT_IC) ? CLIENT_DC : CLIENT_IC;
  endfunction

endpackage

// File: rtl/mem_rr_picker.sv
// mem_rr_picker: two-way round-robin grant. On a tie the client that did
// not win last time is chosen; otherwise the lone requester wins.

module mem_rr_picker
  import mem_arb_pkg::*;
(
  input  logic    i_ic_req,
  input  logic    i_dc_req,
  input  client_t i_last_gnt,
  output logic    o_gnt_valid,
  output client_t o_gnt
);

  // Pure combinational grant selection
  always_comb begin
    o_gnt_valid = i_ic_req | i_dc_req;
    o_gnt       = CLIENT_IC;
    if (i_ic_req && i_dc_req) begin
      o_gnt = other_client(i_last_gnt);
    end else if (i_dc_req) begin
      o_gnt = CLIENT_DC;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises instruction-fetch reads and data-cache reads/writes
// onto a single-ported memory. All outputs are registered.
// Optional read timeout enabled by defining MEM_ARB_TIMEOUT_EN.
//
// state     | meaning
// ----------+--------------------------------------------------
// IDLE      | no transaction; requests sampled here
// READ_WAIT | address held, waiting for mem_valid (or timeout)
// WRITE     | one-cycle write strobe, ack to dc next

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = `MEM_ADDR_SIZE,
  parameter int DATA_W  = `MEM_BANDWIDTH * 8,
  parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_resp_valid,
  output logic [DATA_W-1:0] ic_resp_data,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_resp_valid,
  output logic [DATA_W-1:0] dc_resp_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_valid,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_valid,
  output logic              busy
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  output logic              timeout_err
`endif
);

  arb_state_t        r_state;
  client_t           r_owner;
  client_t           r_last_gnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_mem_wv;
  logic              r_ic_rv;
  logic              r_dc_rv;
  logic [DATA_W-1:0] r_ic_rdata;
  logic [DATA_W-1:0] r_dc_rdata;

  logic              w_gnt_valid;
  client_t           w_gnt;
  logic              w_rd_done;
  logic [DATA_W-1:0] w_rd_data;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout_err;
  logic             w_timeout;
`endif

  mem_rr_picker u_picker (
    .i_ic_req    (ic_req),
    .i_dc_req    (dc_req),
    .i_last_gnt  (r_last_gnt),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt       (w_gnt)
  );

  // Read completion: real data on mem_valid, zero data on timeout
  always_comb begin
    w_rd_done = 1'b0;
    w_rd_data = mem_data;
`ifdef MEM_ARB_TIMEOUT_EN
    w_timeout = 1'b0;
`endif
    if (r_state == READ_WAIT) begin
      if (mem_valid) begin
        w_rd_done = 1'b1;
      end
`ifdef MEM_ARB_TIMEOUT_EN
      else if (r_cnt == CNT_LAST) begin
        w_rd_done = 1'b1;
        w_rd_data = '0;
        w_timeout = 1'b1;
      end
`endif
    end
  end

  // Arbitration FSM with registered memory-side and client-side outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_owner    <= CLIENT_IC;
      r_last_gnt <= CLIENT_DC;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_mem_wv   <= 1'b0;
      r_ic_rv    <= 1'b0;
      r_dc_rv    <= 1'b0;
      r_ic_rdata <= '0;
      r_dc_rdata <= '0;
    end else begin
      r_mem_wv <= 1'b0;
      r_ic_rv  <= 1'b0;
      r_dc_rv  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_gnt_valid) begin
            r_last_gnt <= w_gnt;
            r_owner    <= w_gnt;
            if (w_gnt == CLIENT_IC) begin
              r_addr  <= ic_addr;
              r_state <= READ_WAIT;
            end else begin
              r_addr <= dc_addr;
              if (dc_we) begin
                r_wdata  <= dc_wdata;
                r_mem_wv <= 1'b1;
                r_state  <= WRITE;
              end else begin
                r_state <= READ_WAIT;
              end
            end
          end
        end
        READ_WAIT: begin
          if (w_rd_done) begin
            r_state <= IDLE;
            if (r_owner == CLIENT_IC) begin
              r_ic_rv    <= 1'b1;
              r_ic_rdata <= w_rd_data;
            end else begin
              r_dc_rv    <= 1'b1;
              r_dc_rdata <= w_rd_data;
            end
          end
        end
        WRITE: begin
          r_dc_rv <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  // Read-wait cycle counter and sticky timeout flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state != READ_WAIT) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign timeout_err = r_timeout_err;
`endif

  assign busy            = (r_state != IDLE);
  assign mem_addr        = r_addr;
  assign mem_write_data  = r_wdata;
  assign mem_write_valid = r_mem_wv;
  assign ic_resp_valid   = r_ic_rv;
  assign ic_resp_data    = r_ic_rdata;
  assign dc_resp_valid   = r_dc_rv;
  assign dc_resp_data    = r_dc_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a
// transaction-level memory/arbitration model. Timeout section active only
// when MEM_ARB_TIMEOUT_EN is defined.

`ifndef MEM_ADDR_SIZE
`define MEM_ADDR_SIZE 32
`endif
`ifndef MEM_BANDWIDTH
`define MEM_BANDWIDTH 8
`endif

module tb_mem_arbiter;

  localparam int AW  = `MEM_ADDR_SIZE;
  localparam int DW  = `MEM_BANDWIDTH * 8;
  localparam int TMO = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ic_req = 1'b0;
  logic [AW-1:0] ic_addr = '0;
  logic          ic_resp_valid;
  logic [DW-1:0] ic_resp_data;
  logic          dc_req = 1'b0;
  logic          dc_we = 1'b0;
  logic [AW-1:0] dc_addr = '0;
  logic [DW-1:0] dc_wdata = '0;
  logic          dc_resp_valid;
  logic [DW-1:0] dc_resp_data;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_write_data;
  logic          mem_write_valid;
  logic [DW-1:0] mem_data = '0;
  logic          mem_valid = 1'b0;
  logic          busy;
`ifdef MEM_ARB_TIMEOUT_EN
  logic          timeout_err;
`endif

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ic_req          (ic_req),
    .ic_addr         (ic_addr),
    .ic_resp_valid   (ic_resp_valid),
    .ic_resp_data    (ic_resp_data),
    .dc_req          (dc_req),
    .dc_we           (dc_we),
    .dc_addr         (dc_addr),
    .dc_wdata        (dc_wdata),
    .dc_resp_valid   (dc_resp_valid),
    .dc_resp_data    (dc_resp_data),
    .mem_addr        (mem_addr),
    .mem_write_data  (mem_write_data),
    .mem_write_valid (mem_write_valid),
    .mem_data        (mem_data),
    .mem_valid       (mem_valid),
    .busy            (busy)
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    .timeout_err     (timeout_err)
`endif
  );

  int total = 0;
  int bad = 0;

  // Reference memory contents and the client granted most recently
  logic [DW-1:0] mem_model [logic [AW-1:0]];
  bit            last_ic;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] lookup(input logic [AW-1:0] a);
    if (!mem_model.exists(a)) mem_model[a] = {$urandom, $urandom};
    return mem_model[a];
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    a = AW'($urandom_range(1, 4)) << 6;
    return a;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ic_rv"}, ic_resp_valid, 0);
    chk({tag, "_dc_rv"}, dc_resp_valid, 0);
    chk({tag, "_wv"}, mem_write_valid, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_write_data, 0);
    chk({tag, "_ic_data"}, ic_resp_data, 0);
    chk({tag, "_dc_data"}, dc_resp_data, 0);
`ifdef MEM_ARB_TIMEOUT_EN
    chk({tag, "_terr"}, timeout_err, 0);
`endif
  endtask

  // One transaction: the request must already be set up before the sampling edge
  task automatic serve(input bit is_ic, input bit we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input int lat);
    logic [DW-1:0] d;
    tick();
    chk("busy_after_grant", busy, 1);
    chk("mem_addr_grant", mem_addr, addr);
    if (we) begin
      chk("wr_strobe", mem_write_valid, 1);
      chk("wr_data", mem_write_data, wdata);
      chk("wr_no_early_ack", dc_resp_valid, 0);
      tick();
      chk("wr_strobe_once", mem_write_valid, 0);
      chk("wr_ack", dc_resp_valid, 1);
      chk("wr_ic_quiet", ic_resp_valid, 0);
      chk("idle_after_wr", busy, 0);
      mem_model[addr] = wdata;
    end else begin
      d = lookup(addr);
      chk("rd_no_strobe", mem_write_valid, 0);
      for (int i = 1; i < lat; i++) begin
        tick();
        chk("rd_wait_busy", busy, 1);
        chk("rd_wait_addr", mem_addr, addr);
        chk("rd_wait_ic_quiet", ic_resp_valid, 0);
        chk("rd_wait_dc_quiet", dc_resp_valid, 0);
      end
      mem_valid = 1'b1;
      mem_data  = d;
      tick();
      mem_valid = 1'b0;
      mem_data  = {$urandom, $urandom};
      chk("rd_ic_rv", ic_resp_valid, is_ic);
      chk("rd_dc_rv", dc_resp_valid, !is_ic);
      if (is_ic) chk("rd_ic_data", ic_resp_data, d);
      else       chk("rd_dc_data", dc_resp_data, d);
      chk("idle_after_rd", busy, 0);
    end
    last_ic = is_ic;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit            exp_ic;
    logic [AW-1:0] a;
    logic [DW-1:0] w;

    // Reset state
    tick();
    tick();
    chk_reset_outputs("reset");
    rst_n   = 1'b1;
    last_ic = 1'b0;
    tick();
    chk("idle_no_req", busy, 0);

    // Lone ic read of 0x40, data three cycles after the grant
    mem_model[AW'(32'h40)] = 64'hDEAD_BEEF_CAFE_F00D;
    ic_req  = 1'b1;
    ic_addr = AW'(32'h40);
    serve(1'b1, 1'b0, AW'(32'h40), '0, 3);
    chk("lone_ic_data_const", ic_resp_data, 64'hDEAD_BEEF_CAFE_F00D);
    ic_req = 1'b0;
    tick();
    chk("ic_rv_one_cycle", ic_resp_valid, 0);
    chk("dc_rv_stays_low", dc_resp_valid, 0);

    // Lone dc write, then readback through both clients
    dc_req   = 1'b1;
    dc_we    = 1'b1;
    dc_addr  = AW'(32'h80);
    dc_wdata = 64'h1234;
    serve(1'b0, 1'b1, AW'(32'h80), 64'h1234, 1);
    dc_we = 1'b0;
    serve(1'b0, 1'b0, AW'(32'h80), '0, 2);
    chk("readback_0x80", dc_resp_data, 64'h1234);
    dc_req  = 1'b0;
    ic_req  = 1'b1;
    ic_addr = AW'(32'h80);
    serve(1'b1, 1'b0, AW'(32'h80), '0, 1);
    chk("ic_readback_0x80", ic_resp_data, 64'h1234);
    ic_req = 1'b0;
    tick();
    chk("no_rv_after_readback", ic_resp_valid | dc_resp_valid, 0);

    // Both clients held continuously: grants must alternate
    ic_req   = 1'b1;
    ic_addr  = rand_addr();
    dc_req   = 1'b1;
    dc_we    = 1'($urandom_range(0, 1));
    dc_addr  = rand_addr();
    dc_wdata = {$urandom, $urandom};
    for (int n = 0; n < 10; n++) begin
      exp_ic = !last_ic;
      if (exp_ic) begin
        serve(1'b1, 1'b0, ic_addr, '0, $urandom_range(1, 4));
        ic_addr = rand_addr();
      end else begin
        serve(1'b0, dc_we, dc_addr, dc_wdata, $urandom_range(1, 4));
        dc_we    = 1'($urandom_range(0, 1));
        dc_addr  = rand_addr();
        dc_wdata = {$urandom, $urandom};
      end
    end
    ic_req = 1'b0;
    dc_req = 1'b0;
    tick();
    chk("tie_loop_drain_idle", busy, 0);
    chk("tie_loop_drain_rv", ic_resp_valid | dc_resp_valid, 0);

    // Stale mem_valid while idle, then a normal ic read
    mem_valid = 1'b1;
    mem_data  = {$urandom, $urandom};
    tick();
    tick();
    mem_valid = 1'b0;
    chk("stale_idle_ic_rv", ic_resp_valid, 0);
    chk("stale_idle_dc_rv", dc_resp_valid, 0);
    chk("stale_idle_busy", busy, 0);
    ic_req  = 1'b1;
    ic_addr = AW'(32'h100);
    serve(1'b1, 1'b0, AW'(32'h100), '0, 2);
    ic_req = 1'b0;

    // Stale mem_valid during a write
    dc_req    = 1'b1;
    dc_we     = 1'b1;
    a         = rand_addr();
    w         = {$urandom, $urandom};
    dc_addr   = a;
    dc_wdata  = w;
    mem_valid = 1'b1;
    serve(1'b0, 1'b1, a, w, 1);
    mem_valid = 1'b0;
    dc_req    = 1'b0;
    dc_we     = 1'b0;
    tick();
    chk("stale_wr_single_ack", dc_resp_valid, 0);

    // Asynchronous reset in READ_WAIT
    ic_req  = 1'b1;
    ic_addr = AW'(32'hC0);
    tick();
    chk("pre_reset_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    ic_req    = 1'b0;
    mem_valid = 1'b1;
    mem_data  = {$urandom, $urandom};
    tick();
    tick();
    mem_valid = 1'b0;
    chk_reset_outputs("held_rst");
    rst_n   = 1'b1;
    last_ic = 1'b0;
    tick();
    tick();
    chk("post_rst_ic_rv", ic_resp_valid, 0);
    chk("post_rst_dc_rv", dc_resp_valid, 0);
    chk("post_rst_busy", busy, 0);

    // First tie after reset goes to ic, then the waiting dc read
    ic_req  = 1'b1;
    ic_addr = AW'(32'hC0);
    dc_req  = 1'b1;
    dc_we   = 1'b0;
    dc_addr = AW'(32'h40);
    serve(1'b1, 1'b0, AW'(32'hC0), '0, 1);
    ic_req = 1'b0;
    serve(1'b0, 1'b0, AW'(32'h40), '0, 2);
    dc_req = 1'b0;
    tick();
    chk("final_idle", busy, 0);

`ifdef MEM_ARB_TIMEOUT_EN
    // Read that never gets mem_valid
    ic_req  = 1'b1;
    ic_addr = AW'(32'h140);
    tick();
    chk("tmo_busy", busy, 1);
    for (int i = 1; i < TMO; i++) begin
      tick();
      chk("tmo_wait_rv", ic_resp_valid, 0);
      chk("tmo_wait_err", timeout_err, 0);
    end
    tick();
    chk("tmo_ic_rv", ic_resp_valid, 1);
    chk("tmo_ic_data", ic_resp_data, 0);
    chk("tmo_err_set", timeout_err, 1);
    chk("tmo_idle", busy, 0);
    ic_req = 1'b0;
    tick();
    chk("tmo_err_sticky", timeout_err, 1);
    ic_req  = 1'b1;
    ic_addr = AW'(32'h40);
    serve(1'b1, 1'b0, AW'(32'h40), '0, 2);
    ic_req = 1'b0;
    chk("tmo_err_sticky2", timeout_err, 1);
    rst_n = 1'b0;
    #1;
    chk("tmo_err_cleared", timeout_err, 0);
    tick();
    rst_n = 1'b1;
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-client arbiter between the instruction-fetch path (read-only) and the data-cache path (read/write) and the unified single-ported `memory` model. It serialises requests onto the memory's `mem_addr` / `mem_write_data` / `mem_write_valid` / `mem_data` / `mem_valid` port and returns each read line, or write acknowledge, to the requester. It sits directly upstream of `memory` and drives every one of its inputs.

## Interface
- `ADDR_W`, default `` `MEM_ADDR_SIZE ``: address width.
- `DATA_W`, default `` `MEM_BANDWIDTH*8 ``: line width.
- `TIMEOUT`, default 64: cycle limit for a read (used only with `MEM_ARB_TIMEOUT_EN`).
- Reset and clocking (already decided): one clock; reset is asynchronous and active-low.
- `clk` in 1: clock. All flops update on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ic_req` in 1: instruction-fetch read request.
- `ic_addr` in ADDR_W: fetch address.
- `ic_resp_valid` out 1: fetch data valid, one-cycle pulse.
- `ic_resp_data` out DATA_W: fetch line.
- `dc_req` in 1: data request.
- `dc_we` in 1: 1 = write, 0 = read.
- `dc_addr` in ADDR_W: data address.
- `dc_wdata` in DATA_W: write line.
- `dc_resp_valid` out 1: read data valid, or write acknowledge; one-cycle pulse.
- `dc_resp_data` out DATA_W: read line. Value after a write acknowledge is don't-care.
- `mem_addr` out ADDR_W: to memory.
- `mem_write_data` out DATA_W: to memory.
- `mem_write_valid` out 1: to memory; one-cycle write strobe.
- `mem_data` in DATA_W: from memory.
- `mem_valid` in 1: from memory; read data valid.
- `busy` out 1: high when state ≠ IDLE.
- `timeout_err` out 1: sticky error flag. Present only with `MEM_ARB_TIMEOUT_EN`.

## Operation
- States:
  - IDLE
  - READ_WAIT
  - WRITE
- **Client contract:** a client holds `req` and its fields stable until its `resp_valid`. The arbiter also latches the fields at grant.
- **IDLE:**
  - No request pending: stay in IDLE.
  - One request pending: grant it.
  - Both pending: grant the client that was not granted last (`last_gnt` bit; reset value favours dc, so ic wins the first tie).
  - Granted read → READ_WAIT. Granted dc write → WRITE.
- **READ_WAIT:**
  - `mem_addr` is held at the latched address.
  - On `mem_valid`: latch `mem_data`, pulse the owner's `resp_valid` next cycle, go to IDLE.
- **WRITE:**
  - Drive `mem_addr` and `mem_write_data`, with `mem_write_valid` = 1 for exactly one cycle.
  - Then pulse `dc_resp_valid` and go to IDLE.
  - The memory returns no response for writes.
- **Stale `mem_valid`:** ignored in IDLE and in WRITE.
- **Request timing:** a request is only sampled in IDLE. `req` rising while the arbiter is busy waits; it is never dropped.
- **Reset:** when `rst_n` is asserted at any point, including mid-transaction:
  - Outputs go to: state IDLE, all `resp_valid` = 0, `mem_write_valid` = 0, `mem_addr` = 0, `mem_write_data` = 0, `resp_data` = 0, `busy` = 0, `timeout_err` = 0, `last_gnt` = dc.
  - The outstanding transaction is abandoned.

## Timing
- Request sampled in IDLE at cycle t.
- `mem_addr` and `busy` are registered and valid from t+1.
- **Read:**
  - `mem_valid` arrives at cycle k ≥ t+1.
  - `resp_valid` and `resp_data` are valid at k+1.
  - The state is IDLE at k+1.
  - A new grant can be sampled at k+1, giving one bubble between transactions.
- **Write:**
  - `mem_write_valid` high at t+1.
  - `dc_resp_valid` at t+2.
  - A new grant can be sampled at t+2.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - An 8-bit-minimum counter clears on entry to READ_WAIT and increments each cycle in that state.
  - When it reaches TIMEOUT without `mem_valid`:
    - `timeout_err` is set (sticky until reset).
    - The owner receives `resp_valid` with data = 0.
    - The state returns to IDLE.
- `MEM_ARB_TIMEOUT_EN` undefined:
  - No counter and no `timeout_err` port.
  - READ_WAIT waits indefinitely.

## Structure
- Package `mem_arb_pkg`:
  - `arb_state_t` enum {IDLE, READ_WAIT, WRITE}.
  - `client_t` enum {CLIENT_IC, CLIENT_DC}.
  - `ARB_TIMEOUT_DEFAULT` = 64.
- Sub-module `mem_rr_picker`: 2-way round-robin grant from (`ic_req`, `dc_req`, `last_gnt`). It is combinational and instanced once. The FSM and datapath live in `mem_arbiter`.

## Test plan
- **Lone ic read:** `ic_req`, addr 0x40; memory returns `mem_valid` 3 cycles later with 0xDEAD… → `ic_resp_valid` exactly one cycle later with that data; `dc_resp_valid` stays 0.
- **Lone dc write:** addr 0x80, wdata 0x1234 → `mem_write_valid` for one cycle at t+1 with addr 0x80 and data 0x1234; `dc_resp_valid` at t+2; a later read of 0x80 returns 0x1234.
- **Simultaneous requests:** ic and dc requests held at the same time, repeatedly → grants alternate: ic first after reset, then dc, then ic; each client sees exactly one response per grant.
- **Stale memory response:** `mem_valid` pulsed while IDLE, then an ic read → no spurious `resp_valid`; the ic read returns its correct data.
- **Reset mid-operation:** `rst_n` dropped during READ_WAIT → all outputs 0 immediately (asynchronous); no response after release; the next ic request is serviced normally.
- **Timeout (`MEM_ARB_TIMEOUT_EN`):** `mem_valid` never asserted → at cycle TIMEOUT `timeout_err` = 1 and `ic_resp_valid` = 1 with data 0; `timeout_err` stays 1 until reset.
